// File: rtl/if_fetch_queue.sv
// if_fetch_queue: fetch PC, credit-limited ROM requests and instruction FIFO to ID.
// Define FETCH_PERF_CNT_EN to add the perf_stall_cnt / perf_flush_cnt counters.
module if_fetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input  logic        cpu_clk,
   input  logic        cpu_rst_n,
   output logic        irom_req,
   output logic [31:0] irom_addr,
   input  logic        irom_gnt,
   input  logic        irom_rvalid,
   input  logic [31:0] irom_rdata,
   output logic        id_valid,
   input  logic        id_ready,
   output logic [31:0] id_inst,
   output logic [31:0] id_pc,
   output logic [31:0] id_pc4,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc
`ifdef FETCH_PERF_CNT_EN
   ,
   output logic [31:0] perf_stall_cnt,
   output logic [31:0] perf_flush_cnt
`endif
);

   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);

   logic [31:0]   fetch_pc;
   logic [31:0]   resp_pc;
   logic [CW-1:0] count;
   logic [CW-1:0] outstanding;
   logic [CW-1:0] discard;
   logic [CW-1:0] discard_nxt;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [31:0]   mem_inst [DEPTH];
   logic [31:0]   mem_pc   [DEPTH];
   logic          grant;
   logic          resp;
   logic          drop;
   logic          push;
   logic          pop;
   logic [31:0]   redir_pc;

   // queued + in-flight never exceeds DEPTH, so a push always finds room
   assign irom_req  = cpu_rst_n && !redirect_valid &&
                      (({1'b0, count} + {1'b0, outstanding}) < LIMIT);
   assign irom_addr = fetch_pc;
   assign grant     = irom_req && irom_gnt;
   assign resp      = irom_rvalid && (outstanding != '0);
   assign drop      = resp && (discard != '0);
   assign push      = resp && !drop && !redirect_valid;
   assign id_valid  = (count != '0);
   assign pop       = id_valid && id_ready;
   assign redir_pc  = {redirect_pc[31:2], 2'b00};

   // everything still in flight after this edge belongs to the killed stream
   assign discard_nxt = outstanding - CW'(resp);

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         fetch_pc    <= RESET_PC;
         resp_pc     <= RESET_PC;
         count       <= '0;
         outstanding <= '0;
         discard     <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else if (redirect_valid) begin
         fetch_pc    <= redir_pc;
         resp_pc     <= redir_pc;
         count       <= '0;
         outstanding <= discard_nxt;
         discard     <= discard_nxt;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
      end else begin
         if (grant) fetch_pc <= fetch_pc + 32'd4;
         if (push) resp_pc <= resp_pc + 32'd4;
         if (drop) discard <= discard - CW'(1);
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop) rd_ptr <= rd_ptr + AW'(1);
         outstanding <= outstanding + CW'(grant) - CW'(resp);
         count       <= count + CW'(push) - CW'(pop);
      end
   end

   always_ff @(posedge cpu_clk) begin
      if (push) begin
         mem_inst[wr_ptr] <= irom_rdata;
         mem_pc[wr_ptr]   <= resp_pc;
      end
   end

   assign id_inst = id_valid ? mem_inst[rd_ptr] : '0;
   assign id_pc   = id_valid ? mem_pc[rd_ptr] : '0;
   assign id_pc4  = id_pc + 32'd4;

`ifdef FETCH_PERF_CNT_EN
   logic [32:0] flush_sum;

   assign flush_sum = {1'b0, perf_flush_cnt} + 33'(count) + 33'(discard_nxt);

   always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
      if (!cpu_rst_n) begin
         perf_stall_cnt <= '0;
         perf_flush_cnt <= '0;
      end else begin
         if (id_valid && !id_ready)
            perf_stall_cnt <= perf_stall_cnt + 32'd1;
         if (redirect_valid)
            perf_flush_cnt <= flush_sum[32] ? '1 : flush_sum[31:0];
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_queue.sv
// Bench for if_fetch_queue: in-order ROM model plus expected-PC scoreboard.
// Set FETCH_PERF_CNT_EN to also exercise the perf counters.
module tb_if_fetch_queue;

   logic        cpu_clk = 1'b0;
   logic        cpu_rst_n = 1'b0;
   logic        irom_req;
   logic [31:0] irom_addr;
   logic        irom_gnt = 1'b0;
   logic        irom_rvalid = 1'b0;
   logic [31:0] irom_rdata = '0;
   logic        id_valid;
   logic        id_ready = 1'b0;
   logic [31:0] id_inst;
   logic [31:0] id_pc;
   logic [31:0] id_pc4;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = '0;
`ifdef FETCH_PERF_CNT_EN
   logic [31:0] perf_stall_cnt;
   logic [31:0] perf_flush_cnt;
   logic [31:0] ps_s;
   logic [31:0] pf_s;
`endif

   if_fetch_queue dut (
      .cpu_clk        (cpu_clk),
      .cpu_rst_n      (cpu_rst_n),
      .irom_req       (irom_req),
      .irom_addr      (irom_addr),
      .irom_gnt       (irom_gnt),
      .irom_rvalid    (irom_rvalid),
      .irom_rdata     (irom_rdata),
      .id_valid       (id_valid),
      .id_ready       (id_ready),
      .id_inst        (id_inst),
      .id_pc          (id_pc),
      .id_pc4         (id_pc4),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc)
`ifdef FETCH_PERF_CNT_EN
      ,
      .perf_stall_cnt (perf_stall_cnt),
      .perf_flush_cnt (perf_flush_cnt)
`endif
   );

   always #5 cpu_clk = ~cpu_clk;

   int          n_vec = 0;
   int          n_bad = 0;
   int          grants = 0;
   int          pops = 0;
   logic [31:0] exp_q[$];
   logic [31:0] pend[$];
   logic [31:0] exp_fetch = '0;
   logic        req_s;
   logic        vld_s;
   logic [31:0] pid_s;

   function automatic logic [31:0] inst_of(input logic [31:0] a);
      return a ^ 32'h5A5A_0F0F ^ {a[15:0], a[31:16]};
   endfunction

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic gnt, input logic rdy, input logic rsp,
                      input logic rdr = 1'b0,
                      input logic [31:0] rpc = 32'h0);
      logic        g;
      logic        rv;
      logic [31:0] e;
      @(negedge cpu_clk);
      irom_gnt       = gnt;
      id_ready       = rdy;
      redirect_valid = rdr;
      redirect_pc    = rpc;
      rv             = rsp && (pend.size() > 0);
      irom_rvalid    = rv;
      irom_rdata     = rv ? inst_of(pend[0]) : 32'hDEAD_BEEF;
      #1;
      req_s = irom_req;
      vld_s = id_valid;
      pid_s = id_pc;
`ifdef FETCH_PERF_CNT_EN
      ps_s = perf_stall_cnt;
      pf_s = perf_flush_cnt;
`endif
      if (rdr) chk("rdr_req", 32'(irom_req), 32'h0);
      if (id_valid && id_ready) begin
         pops++;
         if (exp_q.size() == 0) begin
            chk("unexp_pop", id_pc, 32'hFFFF_FFFF);
         end else begin
            e = exp_q.pop_front();
            chk("id_pc", id_pc, e);
            chk("id_pc4", id_pc4, e + 32'd4);
            chk("id_inst", id_inst, inst_of(e));
         end
      end
      g = irom_req && irom_gnt;
      if (g) begin
         chk("irom_addr", irom_addr, exp_fetch);
         exp_q.push_back(exp_fetch);
         pend.push_back(irom_addr);
         exp_fetch = exp_fetch + 32'd4;
         grants++;
      end
      @(posedge cpu_clk);
      if (rv) void'(pend.pop_front());
      if (rdr) begin
         exp_q.delete();
         exp_fetch = {rpc[31:2], 2'b00};
      end
   endtask

   task automatic drain();
      for (int i = 0; i < 30; i++) begin
         if (pend.size() == 0 && exp_q.size() == 0) break;
         cyc(1'b0, 1'b1, 1'b1);
      end
      chk("drain", 32'(exp_q.size()), 32'h0);
   endtask

   task automatic do_reset();
      @(negedge cpu_clk);
      cpu_rst_n      = 1'b0;
      irom_gnt       = 1'b0;
      irom_rvalid    = 1'b0;
      redirect_valid = 1'b0;
      id_ready       = 1'b0;
      #1;
      chk("rst_req", 32'(irom_req), 32'h0);
      chk("rst_addr", irom_addr, 32'h0);
      chk("rst_valid", 32'(id_valid), 32'h0);
      chk("rst_inst", id_inst, 32'h0);
      chk("rst_pc", id_pc, 32'h0);
      chk("rst_pc4", id_pc4, 32'h4);
      exp_q.delete();
      exp_fetch = 32'h0;
      repeat (2) @(posedge cpu_clk);
      @(negedge cpu_clk);
      cpu_rst_n = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
`ifdef FETCH_PERF_CNT_EN
      logic [31:0] p0;
`endif
      // streaming from reset: addresses 0,4,8.. and first valid at cycle 2
      do_reset();
      pend.delete();
      pops = 0;
      cyc(1'b1, 1'b1, 1'b1);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t1_v_c1", 32'(vld_s), 32'h0);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t1_v_c2", 32'(vld_s), 32'h1);
      chk("t1_pc0", pid_s, 32'h0);
      repeat (7) cyc(1'b1, 1'b1, 1'b1);
      chk("t1_rate", 32'(pops), 32'd8);
      drain();

      // stall: credit fills at 4, head holds pc 0
      do_reset();
      pend.delete();
      grants = 0;
      for (int i = 0; i < 9; i++) begin
         cyc(1'b1, 1'b0, 1'b1);
`ifdef FETCH_PERF_CNT_EN
         if (i == 3) p0 = ps_s;
`endif
      end
      chk("t2_grants", 32'(grants), 32'd4);
      chk("t2_req", 32'(req_s), 32'h0);
      chk("t2_valid", 32'(vld_s), 32'h1);
      chk("t2_head", pid_s, 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_stall", ps_s - p0, 32'd5);
`endif
      repeat (6) cyc(1'b1, 1'b1, 1'b1);
      drain();

      // redirect with 2 queued, 2 in flight
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_1002);
      cyc(1'b1, 1'b1, 1'b1);
      chk("t3_valid", 32'(vld_s), 32'h0);
      repeat (8) cyc(1'b1, 1'b1, 1'b1);
      drain();

      // redirect coinciding with the only response
      cyc(1'b1, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_2000);
      pops = 0;
      repeat (6) cyc(1'b1, 1'b1, 1'b1);
      chk("t4_pops", 32'(pops), 32'd4);
      drain();

      // reset with 3 in flight, then stale responses
      repeat (3) cyc(1'b1, 1'b0, 1'b0);
      do_reset();
      repeat (3) cyc(1'b0, 1'b1, 1'b1);
      cyc(1'b0, 1'b1, 1'b0);
      chk("t5_valid", 32'(vld_s), 32'h0);
      chk("t5_pend", 32'(pend.size()), 32'h0);
      repeat (6) cyc(1'b1, 1'b1, 1'b1);
      drain();

      // redirect killing 3 queued and 1 in flight
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b1, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b1, 32'h0000_3000);
`ifdef FETCH_PERF_CNT_EN
      p0 = pf_s;
`endif
      cyc(1'b1, 1'b1, 1'b1);
      chk("t6_valid", 32'(vld_s), 32'h0);
`ifdef FETCH_PERF_CNT_EN
      chk("perf_flush", pf_s - p0, 32'd4);
`endif
      repeat (6) cyc(1'b1, 1'b1, 1'b1);
      drain();

      chk("final_sb", 32'(exp_q.size()), 32'h0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
